// File: rtl/sst_seq_pkg.sv
// ---------------------------------------------------------------------------
// sst_seq_pkg
//   Shared definitions for the save-state sequencer:
//     state_t      - sequencer FSM states
//     DIR_SAVE     - dir value selecting mapper -> memory transfer
//     DIR_RESTORE  - dir value selecting memory -> mapper transfer
//     CRC8_POLY    - polynomial of the optional transfer checksum
// ---------------------------------------------------------------------------
package sst_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    SAVE_WAIT,
    SAVE_WR,
    RST_RD,
    RST_ARM,
    RST_HOLD,
    NEXT,
    FIN
  } state_t;

  localparam logic DIR_SAVE    = 1'b0;
  localparam logic DIR_RESTORE = 1'b1;

  localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/sst_seq_m2_edge.sv
// ---------------------------------------------------------------------------
// m2_edge
//   Brings the asynchronous CPU M2 clock into the clk domain through a
//   two-flop synchroniser and produces a one-clk pulse on every
//   synchronised 1->0 transition.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   cpu_m2   in   raw CPU M2, asynchronous to clk
//   m2_fall  out  one-clk pulse per detected M2 falling edge
// ---------------------------------------------------------------------------
module m2_edge (
  input  logic clk,
  input  logic rst,
  input  logic cpu_m2,
  output logic m2_fall
);

  logic m2_meta;
  logic m2_sync;
  logic m2_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      m2_meta <= 1'b0;
      m2_sync <= 1'b0;
      m2_prev <= 1'b0;
    end else begin
      m2_meta <= cpu_m2;
      m2_sync <= m2_meta;
      m2_prev <= m2_sync;
    end
  end

  // Reset clears m2_prev, so M2 already high at reset release gives no
  // false edge.
  assign m2_fall = m2_prev & ~m2_sync;

endmodule

// File: rtl/sst_seq.sv
// ---------------------------------------------------------------------------
// sst_seq
//   Save-state sequencer, initiator side of the mapper SST register bus.
//   Walks SST addresses 0..ADDR_LAST, either copying mapper registers into
//   state memory (save) or writing state memory back into the mapper
//   (restore). Every bus step is paced to M2 falling edges because the
//   mapper commits SST writes on negedge M2.
//
// Optional build macro:
//   SST_CRC_EN - adds output crc[7:0], CRC-8 (poly 0x07, init 0, MSB
//                first) over every transferred byte; cleared on start,
//                valid when done pulses.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cpu_m2              raw CPU M2 (asynchronous)
//   start, dir, base    request pulse, direction (0 save / 1 restore),
//                       state memory base address
//   busy, done          sequence active / one-clk completion pulse
//   sst_act             SST mode towards the mapper
//   sst_addr            SST register address
//   sst_we_reg          SST write strobe (spans exactly one M2 negedge)
//   sst_dato, sst_di    restore data out / save data in
//   mem_addr            base + SST address, wraps mod 2^MEM_AW
//   mem_req, mem_we     memory request (held until mem_ack), 1 = write
//   mem_dout, mem_din   save data out / restore data in
//   mem_ack             one-clk memory acknowledge
// ---------------------------------------------------------------------------
module sst_seq
  import sst_seq_pkg::*;
#(
  parameter int ADDR_LAST = 255,
  parameter int MEM_AW    = 16,
  parameter int SETTLE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_m2,
  input  logic              start,
  input  logic              dir,
  input  logic [MEM_AW-1:0] base,
  output logic              busy,
  output logic              done,
  output logic              sst_act,
  output logic [7:0]        sst_addr,
  output logic              sst_we_reg,
  output logic [7:0]        sst_dato,
  input  logic [7:0]        sst_di,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack
`ifdef SST_CRC_EN
  ,
  output logic [7:0]        crc
`endif
);

  localparam int              CNT_W     = $clog2(SETTLE + 2);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);
  localparam logic [8:0]       LAST_V   = 9'(ADDR_LAST);

  state_t            state, state_nxt;
  logic              dir_r, dir_nxt;
  logic [MEM_AW-1:0] base_r, base_nxt;
  logic [8:0]        addr, addr_nxt;
  logic              arm_edge, arm_edge_nxt;
  logic              settling, settling_nxt;
  logic [CNT_W-1:0]  settle_cnt, settle_cnt_nxt;
  logic [7:0]        dout_nxt;
  logic [7:0]        dato_nxt;
  logic              done_nxt;
  logic              m2_fall;
  logic              save_cap;
  logic              rest_cap;

  m2_edge u_m2_edge (
    .clk     (clk),
    .rst     (rst),
    .cpu_m2  (cpu_m2),
    .m2_fall (m2_fall)
  );

  // Control outputs are decoded straight from the state register so a
  // reset clears them on the very next clk, even in the middle of a hold.
  assign busy       = (state != IDLE);
  assign sst_act    = (state != IDLE);
  assign sst_we_reg = (state == RST_HOLD);
  assign mem_req    = (state == SAVE_WR) || (state == RST_RD);
  assign mem_we     = (state == SAVE_WR);
  assign sst_addr   = addr[7:0];
  assign mem_addr   = base_r + MEM_AW'(addr);

  // Save byte is sampled SETTLE clks after the M2 edge pulse; with
  // SETTLE=0 it is taken on the edge pulse itself.
  assign save_cap = (state == SAVE_WAIT) &&
                    (settling ? (settle_cnt <= CNT_W'(1)) : ((SETTLE == 0) && m2_fall));
  assign rest_cap = (state == RST_RD) && mem_ack;

  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir_r;
    base_nxt       = base_r;
    addr_nxt       = addr;
    arm_edge_nxt   = arm_edge;
    settling_nxt   = settling;
    settle_cnt_nxt = settle_cnt;
    dout_nxt       = mem_dout;
    dato_nxt       = sst_dato;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          dir_nxt      = dir;
          base_nxt     = base;
          addr_nxt     = 9'd0;
          arm_edge_nxt = 1'b0;
          settling_nxt = 1'b0;
          state_nxt    = ARM;
        end
      end

      // Two full M2 edges with act high before the first access.
      ARM: begin
        if (m2_fall) begin
          if (arm_edge) begin
            arm_edge_nxt = 1'b0;
            state_nxt    = (dir_r == DIR_RESTORE) ? RST_RD : SAVE_WAIT;
          end else begin
            arm_edge_nxt = 1'b1;
          end
        end
      end

      SAVE_WAIT: begin
        if (save_cap) begin
          dout_nxt     = sst_di;
          settling_nxt = 1'b0;
          state_nxt    = SAVE_WR;
        end else if (settling) begin
          settle_cnt_nxt = settle_cnt - CNT_W'(1);
        end else if (m2_fall) begin
          settling_nxt   = 1'b1;
          settle_cnt_nxt = SETTLE_V;
        end
      end

      SAVE_WR: begin
        if (mem_ack) state_nxt = NEXT;
      end

      RST_RD: begin
        if (rest_cap) begin
          dato_nxt  = mem_din;
          state_nxt = RST_ARM;
        end
      end

      // we_reg rises after one negedge and falls after the next, so the
      // mapper sees exactly one negedge with the strobe high.
      RST_ARM: begin
        if (m2_fall) state_nxt = RST_HOLD;
      end

      RST_HOLD: begin
        if (m2_fall) state_nxt = NEXT;
      end

      NEXT: begin
        if (addr == LAST_V) begin
          state_nxt = FIN;
        end else begin
          addr_nxt  = addr + 9'd1;
          state_nxt = (dir_r == DIR_RESTORE) ? RST_RD : SAVE_WAIT;
        end
      end

      FIN: begin
        if (m2_fall) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir_r      <= DIR_SAVE;
      base_r     <= '0;
      addr       <= 9'd0;
      arm_edge   <= 1'b0;
      settling   <= 1'b0;
      settle_cnt <= '0;
      mem_dout   <= 8'd0;
      sst_dato   <= 8'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir_r      <= dir_nxt;
      base_r     <= base_nxt;
      addr       <= addr_nxt;
      arm_edge   <= arm_edge_nxt;
      settling   <= settling_nxt;
      settle_cnt <= settle_cnt_nxt;
      mem_dout   <= dout_nxt;
      sst_dato   <= dato_nxt;
      done       <= done_nxt;
    end
  end

`ifdef SST_CRC_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] acc, input logic [7:0] data);
    logic [7:0] c;
    c = acc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 8'd0;
    end else if ((state == IDLE) && start) begin
      crc <= 8'd0;
    end else if (save_cap) begin
      crc <= crc8_byte(crc, sst_di);
    end else if (rest_cap) begin
      crc <= crc8_byte(crc, mem_din);
    end
  end
`else
  // Checksum disabled: no crc port and no checksum logic.
`endif

endmodule

// File: tb/tb_sst_seq.sv
module tb_sst_seq;

  localparam int MEM_AW = 16;
  localparam int NREG   = 256;
  localparam int BUDGET = 20000;

  logic              clk;
  logic              rst;
  logic              cpu_m2;
  logic              start;
  logic              dir;
  logic [MEM_AW-1:0] base;
  logic              busy;
  logic              done;
  logic              sst_act;
  logic [7:0]        sst_addr;
  logic              sst_we_reg;
  logic [7:0]        sst_dato;
  logic [7:0]        sst_di;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_ack;
`ifdef SST_CRC_EN
  logic [7:0]        crc;
`endif

  sst_seq #(.ADDR_LAST(255), .MEM_AW(MEM_AW), .SETTLE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_m2     (cpu_m2),
    .start      (start),
    .dir        (dir),
    .base       (base),
    .busy       (busy),
    .done       (done),
    .sst_act    (sst_act),
    .sst_addr   (sst_addr),
    .sst_we_reg (sst_we_reg),
    .sst_dato   (sst_dato),
    .sst_di     (sst_di),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_ack    (mem_ack)
`ifdef SST_CRC_EN
    ,
    .crc        (crc)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Mapper model and state memory model
  logic [7:0] map_regs [0:NREG-1];
  logic [7:0] mem      [0:65535];
  logic [7:0] orig     [0:NREG-1];
  int         ack_delay = 0;
  int         wr_cnt, rd_cnt, done_cnt, ev_cnt, pulse_cnt, pulse_bad, stable_bad, pulse_negs;
  logic [7:0] ev_addr [$];
  logic [7:0] ev_data [$];

  assign sst_di = map_regs[sst_addr];

  // clk edges fall on multiples of 5; M2 edges on 2 mod 5, never coincident
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cpu_m2 = 1'b0;
    #2;
    forever #55 cpu_m2 = ~cpu_m2;
  end

  // Mapper: commits a write on negedge M2 when act and we_reg are high
  always @(negedge cpu_m2) begin
    if (sst_act === 1'b1 && sst_we_reg === 1'b1) begin
      map_regs[sst_addr] = sst_dato;
      ev_addr.push_back(sst_addr);
      ev_data.push_back(sst_dato);
      ev_cnt++;
      pulse_negs++;
    end
  end

  always @(negedge sst_we_reg) begin
    pulse_cnt++;
    if (pulse_negs != 1) pulse_bad++;
    pulse_negs = 0;
  end

  // Memory responder: acks a request after ack_delay extra clks
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    mem_din  = 8'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_dout;
            wr_cnt++;
          end else begin
            mem_din = mem[mem_addr];
            rd_cnt++;
          end
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitors: done pulses and address/data stability under we_reg
  logic       we_prev = 1'b0;
  logic [7:0] hold_addr, hold_dato;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (sst_we_reg === 1'b1) begin
      if (!we_prev) begin
        hold_addr = sst_addr;
        hold_dato = sst_dato;
      end else if (sst_addr !== hold_addr || sst_dato !== hold_dato) begin
        stable_bad++;
      end
    end
    we_prev = sst_we_reg;
  end

  function automatic logic [7:0] ref_crc8(input logic [7:0] acc, input logic [7:0] d);
    logic [15:0] v;
    v = {acc ^ d, 8'h00};
    for (int b = 15; b >= 8; b--) begin
      if (v[b]) v = v ^ (16'h0107 << (b - 8));
    end
    return v[7:0];
  endfunction

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; ev_cnt = 0;
    pulse_cnt = 0; pulse_bad = 0; stable_bad = 0; pulse_negs = 0;
    ev_addr.delete();
    ev_data.delete();
  endtask

  task automatic start_seq(input logic d, input logic [MEM_AW-1:0] b);
    @(negedge clk);
    start = 1'b1;
    dir   = d;
    base  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dir = 1'b0; base = '0;
    repeat (3) @(negedge clk);
    total++; if ({busy, done, sst_act, sst_we_reg, mem_req, mem_we} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {busy, done, sst_act, sst_we_reg, mem_req, mem_we});
    end
    total++; if (sst_addr !== 8'd0) begin bad++; $display("FAIL reset_sst_addr got=%h want=00", sst_addr); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0000", mem_addr); end
    total++; if ({sst_dato, mem_dout} !== 16'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0000", {sst_dato, mem_dout});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_save();
    logic ok;
    int   errs;
    logic [7:0] exp;
    for (int i = 0; i < NREG; i++) map_regs[i] = 8'(i) ^ 8'hA5;
    clear_stats();
    start_seq(1'b0, 16'h1000);
    total++; if (busy !== 1'b1 || sst_act !== 1'b1) begin
      bad++; $display("FAIL save_busy got=%b%b want=11", busy, sst_act);
    end
    wait_done(BUDGET, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL save_timeout got=no_done want=done"); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i) ^ 8'hA5;
      total++; if (mem[16'h1000 + i] !== exp) begin
        bad++; $display("FAIL save_byte%0d got=%h want=%h", i, mem[16'h1000 + i], exp);
      end
    end
    errs = 0;
    for (int i = 0; i < NREG; i++) if (mem[16'h1000 + i] !== (8'(i) ^ 8'hA5)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL save_all got=%0d_wrong want=0", errs); end
    total++; if (wr_cnt !== NREG || rd_cnt !== 0) begin
      bad++; $display("FAIL save_accesses got=wr%0d_rd%0d want=wr256_rd0", wr_cnt, rd_cnt);
    end
    total++; if (done_cnt !== 1 || ev_cnt !== 0) begin
      bad++; $display("FAIL save_done_once got=done%0d_ev%0d want=done1_ev0", done_cnt, ev_cnt);
    end
    total++; if (sst_act !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL save_idle got=act%b_busy%b want=act0_busy0", sst_act, busy);
    end
  endtask

  task automatic test_restore();
    logic ok;
    int   errs;
    logic [7:0] e0, e1, e2;
    for (int i = 0; i < NREG; i++) begin
      mem[16'h2000 + i] = 8'($urandom);
      map_regs[i]       = 8'($urandom);
    end
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22; mem[16'h2002] = 8'h33;
    clear_stats();
    start_seq(1'b1, 16'h2000);
    wait_done(BUDGET, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL restore_timeout got=no_done want=done"); end
    @(negedge clk);
    total++; if (ev_cnt !== NREG || pulse_cnt !== NREG) begin
      bad++; $display("FAIL restore_writes got=ev%0d_pulse%0d want=256", ev_cnt, pulse_cnt);
    end
    if (ev_addr.size() >= 3) begin
      e0 = ev_data[0]; e1 = ev_data[1]; e2 = ev_data[2];
      total++; if ({ev_addr[0], ev_addr[1], ev_addr[2]} !== 24'h000102 || {e0, e1, e2} !== 24'h112233) begin
        bad++; $display("FAIL restore_first3 got=a%h%h%h_d%h%h%h want=a000102_d112233",
                        ev_addr[0], ev_addr[1], ev_addr[2], e0, e1, e2);
      end
    end else begin
      total++; bad++; $display("FAIL restore_first3 got=%0d_events want=3+", ev_addr.size());
    end
    total++; if (pulse_bad !== 0 || stable_bad !== 0) begin
      bad++; $display("FAIL restore_pulse_shape got=bad%0d_unstable%0d want=0_0", pulse_bad, stable_bad);
    end
    errs = 0;
    for (int i = 0; i < NREG; i++) if (map_regs[i] !== mem[16'h2000 + i]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL restore_regs got=%0d_wrong want=0", errs); end
    total++; if (rd_cnt !== NREG || wr_cnt !== 0 || done_cnt !== 1) begin
      bad++; $display("FAIL restore_accesses got=rd%0d_wr%0d_done%0d want=rd256_wr0_done1", rd_cnt, wr_cnt, done_cnt);
    end
  endtask

  task automatic test_round_trip();
    logic ok;
    int   errs;
    for (int i = 0; i < NREG; i++) begin
      orig[i]     = 8'($urandom);
      map_regs[i] = orig[i];
    end
    clear_stats();
    start_seq(1'b0, 16'hFF80);
    wait_done(BUDGET, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rt_save_timeout got=no_done want=done"); end
    total++; if (mem[16'h0048] !== orig[200]) begin
      bad++; $display("FAIL rt_addr_wrap got=%h want=%h", mem[16'h0048], orig[200]);
    end
    for (int i = 0; i < NREG; i++) map_regs[i] = ~orig[i] ^ 8'(i);
    start_seq(1'b1, 16'hFF80);
    wait_done(BUDGET, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rt_restore_timeout got=no_done want=done"); end
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < NREG; i++) if (map_regs[i] !== orig[i]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL rt_regs got=%0d_wrong want=0", errs); end
    total++; if (wr_cnt !== NREG || rd_cnt !== NREG || done_cnt !== 2) begin
      bad++; $display("FAIL rt_accesses got=wr%0d_rd%0d_done%0d want=256_256_2", wr_cnt, rd_cnt, done_cnt);
    end
  endtask

  task automatic test_rst_mid();
    logic found;
    int   ev_snap;
    for (int i = 0; i < NREG; i++) mem[16'h3000 + i] = 8'($urandom);
    clear_stats();
    start_seq(1'b1, 16'h3000);
    found = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (sst_we_reg === 1'b1 && sst_addr === 8'd5) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rstmid_reach got=not_reached want=hold_at_5"); end
    rst = 1'b1;
    ev_snap = ev_cnt;
    @(negedge clk);
    total++; if ({sst_we_reg, sst_act, busy, mem_req} !== 4'b0) begin
      bad++; $display("FAIL rstmid_outputs got=%b want=0000", {sst_we_reg, sst_act, busy, mem_req});
    end
    rst = 1'b0;
    repeat (600) @(negedge clk);
    total++; if (ev_cnt !== ev_snap || sst_act !== 1'b0 || done_cnt !== 0) begin
      bad++; $display("FAIL rstmid_quiet got=ev%0d_act%b_done%0d want=ev%0d_act0_done0", ev_cnt, sst_act, done_cnt, ev_snap);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int   errs;
    for (int i = 0; i < NREG; i++) map_regs[i] = 8'($urandom);
    for (int i = 0; i < NREG; i++) mem[16'h5000 + i] = 8'($urandom);
    ack_delay = 7;
    clear_stats();
    start_seq(1'b0, 16'h4000);
    repeat (50) @(negedge clk);
    start_seq(1'b1, 16'h5000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    wait_done(2 * BUDGET, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=no_done want=done"); end
    repeat (200) @(negedge clk);
    errs = 0;
    for (int i = 0; i < NREG; i++) if (mem[16'h4000 + i] !== map_regs[i]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL b2b_data got=%0d_wrong want=0", errs); end
    total++; if (wr_cnt !== NREG || rd_cnt !== 0 || done_cnt !== 1 || ev_cnt !== 0) begin
      bad++; $display("FAIL b2b_counts got=wr%0d_rd%0d_done%0d_ev%0d want=256_0_1_0", wr_cnt, rd_cnt, done_cnt, ev_cnt);
    end
    ack_delay = 0;
  endtask

`ifdef SST_CRC_EN
  task automatic test_crc();
    logic ok;
    logic [7:0] exp;
    for (int i = 0; i < NREG; i++) map_regs[i] = (i < 3) ? 8'(i + 1) : 8'($urandom);
    exp = 8'd0;
    for (int i = 0; i < NREG; i++) exp = ref_crc8(exp, map_regs[i]);
    clear_stats();
    start_seq(1'b0, 16'h6000);
    wait_done(BUDGET, ok);
    total++; if (ok !== 1'b1 || crc !== exp) begin
      bad++; $display("FAIL crc_save got=%h want=%h", crc, exp);
    end
  endtask
`endif

  initial begin
    clear_stats();
    test_reset();
    test_save();
    test_restore();
    test_round_trip();
    test_rst_mid();
    test_back_to_back();
`ifdef SST_CRC_EN
    test_crc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
